// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding controller for the 5-stage RV32I pipeline.
// A shadow pipeline tracks rd/write-enable metadata; the outputs are operand selects and stall/flush controls.
module hazard_forward_unit #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int SEL_WIDTH      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
  input  logic [REG_ADDR_WIDTH-1:0] rd_d,
  input  logic                      reg_write_d,
  input  logic [1:0]                result_src_d,
  input  logic                      pc_src_e,
  output logic [SEL_WIDTH-1:0]      forward_a_e,
  output logic [SEL_WIDTH-1:0]      forward_b_e,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      flush_d,
  output logic                      flush_e
);

  localparam logic [SEL_WIDTH-1:0] FWD_RF  = SEL_WIDTH'(2'b00);
  localparam logic [SEL_WIDTH-1:0] FWD_WB  = SEL_WIDTH'(2'b01);
  localparam logic [SEL_WIDTH-1:0] FWD_MEM = SEL_WIDTH'(2'b10);
  localparam logic [1:0]           RESULT_SRC_LOAD = 2'b01;

  // Execute-stage shadow registers
  logic [REG_ADDR_WIDTH-1:0] r_rs1_e;
  logic [REG_ADDR_WIDTH-1:0] r_rs2_e;
  logic [REG_ADDR_WIDTH-1:0] r_rd_e;
  logic                      r_reg_write_e;
  logic                      r_load_e;

  // Memory and Writeback shadow registers
  logic [REG_ADDR_WIDTH-1:0] r_rd_m;
  logic                      r_reg_write_m;
  logic [REG_ADDR_WIDTH-1:0] r_rd_w;
  logic                      r_reg_write_w;

  logic w_lwstall;
  logic w_flush_e;
  logic w_load_d;

  // Memory stage wins over Writeback; x0 is hardwired zero and never forwarded.
  function automatic logic [SEL_WIDTH-1:0] fwd_sel(input logic [REG_ADDR_WIDTH-1:0] src);
    logic [SEL_WIDTH-1:0] sel;
    sel = FWD_RF;
    if (r_reg_write_m && (r_rd_m != '0) && (r_rd_m == src)) begin
      sel = FWD_MEM;
    end else if (r_reg_write_w && (r_rd_w != '0) && (r_rd_w == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

  assign w_load_d    = (result_src_d == RESULT_SRC_LOAD);
  assign forward_a_e = fwd_sel(r_rs1_e);
  assign forward_b_e = fwd_sel(r_rs2_e);

  assign w_lwstall = r_load_e && (r_rd_e != '0) &&
                     ((r_rd_e == rs1_d) || (r_rd_e == rs2_d));

  // A taken branch flushes Decode anyway, so a coincident load-use stall is dropped.
  assign stall_f   = w_lwstall && !pc_src_e;
  assign stall_d   = w_lwstall && !pc_src_e;
  assign flush_d   = pc_src_e;
  assign w_flush_e = w_lwstall || pc_src_e;
  assign flush_e   = w_flush_e;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rs1_e       <= '0;
      r_rs2_e       <= '0;
      r_rd_e        <= '0;
      r_reg_write_e <= 1'b0;
      r_load_e      <= 1'b0;
      r_rd_m        <= '0;
      r_reg_write_m <= 1'b0;
      r_rd_w        <= '0;
      r_reg_write_w <= 1'b0;
    end else begin
      if (w_flush_e) begin
        r_rs1_e       <= '0;
        r_rs2_e       <= '0;
        r_rd_e        <= '0;
        r_reg_write_e <= 1'b0;
        r_load_e      <= 1'b0;
      end else begin
        r_rs1_e       <= rs1_d;
        r_rs2_e       <= rs2_d;
        r_rd_e        <= rd_d;
        r_reg_write_e <= reg_write_d;
        r_load_e      <= w_load_d;
      end
      r_rd_m        <= r_rd_e;
      r_reg_write_m <= r_reg_write_e;
      r_rd_w        <= r_rd_m;
      r_reg_write_w <= r_reg_write_m;
    end
  end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Pipeline hazard controller for the 5-stage RV32I core. It tracks destination-register and write-enable metadata through the Execute, Memory and Writeback stages in its own shadow pipeline. From that state it generates the 2-bit forwarding selects for the Execute-stage operand muxes (encoding 00 register file, 01 writeback result, 10 memory-stage ALU result). It also generates the stall and flush controls for load-use and taken-branch hazards, so it is the producer of the `sel` inputs that the 3-input operand muxes consume.

## Interface
Parameters:
- REG_ADDR_WIDTH, 5, register index width
- SEL_WIDTH, 2, forwarding select width; fixed to match the 3-input operand mux

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset; clears all shadow-pipeline state immediately
- rs1_d  in  REG_ADDR_WIDTH  source register 1 of the Decode-stage instruction
- rs2_d  in  REG_ADDR_WIDTH  source register 2 of the Decode-stage instruction
- rd_d  in  REG_ADDR_WIDTH  destination register of the Decode-stage instruction
- reg_write_d  in  1  Decode-stage instruction writes the register file
- result_src_d  in  2  Decode-stage result source; 2'b01 means load
- pc_src_e  in  1  branch/jump taken, resolved in Execute
- forward_a_e  out  SEL_WIDTH  select for Execute operand A mux
- forward_b_e  out  SEL_WIDTH  select for Execute operand B mux
- stall_f  out  1  hold PC register
- stall_d  out  1  hold Fetch/Decode pipeline register
- flush_d  out  1  clear Fetch/Decode pipeline register
- flush_e  out  1  clear Decode/Execute pipeline register

## Operation
Shadow state:
- E stage holds rs1_e, rs2_e, rd_e, reg_write_e, load_e.
- M stage holds rd_m, reg_write_m.
- W stage holds rd_w, reg_write_w.
- A bubble is every field zero.

Per-edge update:
- E ← bubble if flush_e, else Decode inputs (load = result_src_d == 2'b01).
- M ← E.
- W ← M.
- Outputs are combinational from shadow state and current inputs.

Forwarding (forward_a_e shown; forward_b_e is identical using rs2_e):
- 2'b10 if reg_write_m && rd_m != 0 && rd_m == rs1_e.
- else 2'b01 if reg_write_w && rd_w != 0 && rd_w == rs1_e.
- else 2'b00.
- Memory stage has priority over Writeback. 2'b11 is never driven. x0 is never forwarded.

Load-use detection:
- lwstall = load_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d).

Controls:
- stall_f = stall_d = lwstall && !pc_src_e
- flush_d = pc_src_e
- flush_e = lwstall || pc_src_e

Boundary conditions:
- A taken branch coincident with lwstall suppresses the stall. The Decode instruction is being flushed, so stalling would waste a cycle.
- A load with rd = x0 never stalls.
- Both sources matching the load rd produce a single stall.
- Only rs1_d/rs2_d are compared. Instructions without rs2 may cause a spurious stall, which is permitted and functionally safe.

## Timing
- Reset (async, any cycle, including mid-stall):
  - All shadow fields go to 0.
  - forward_a_e = forward_b_e = 2'b00 and stall_f = stall_d = 0 immediately.
  - flush_d/flush_e follow pc_src_e only.
- Forwarding is a zero-latency combinational function of state registered on the previous edge.
- Load-use stall lasts exactly one cycle. Sequence:
  - Cycle n: load in E, dependent in D → stall_f = stall_d = flush_e = 1.
  - Cycle n+1: bubble in E, dependent still in D → controls 0.
  - Cycle n+2: dependent in E, load in W → select 2'b01.
- Taken branch: flush_d = flush_e = 1 for the single cycle pc_src_e is high. The two bubbles reach M/W on the following edges and never forward.
- No handshake; the unit never blocks.

## Test plan
- Reset asserted mid-stream with reg_write_m = 1, rd_m = 5:
  - required: forward_* = 00 and all stall/flush = 0 before the next edge.
  - required: remain so after release with idle inputs.
- add x5 then sub x6,x5,x1:
  - required: forward_a_e = 10 in the cycle sub is in E.
  - required: an instruction reading x5 as rs2 two cycles after the add gives forward_b_e = 01.
- Two consecutive writes to x7, then a reader of x7:
  - required: forward_a_e = 10 (M wins over W).
- Writer with rd = x0 and reg_write = 1, followed by a reader of x0:
  - required: forward = 00.
- lw x6 then add x7,x6,x6:
  - required: one cycle with stall_f = stall_d = flush_e = 1.
  - required: then both forward selects = 01 two cycles later.
  - required: no second stall.
- lw x6 in E, dependent in D, pc_src_e = 1 in the same cycle:
  - required: flush_d = flush_e = 1, stall_f = stall_d = 0.
  - required: the dependent instruction never appears in E.
